rlwe_enc2_mod_reduce: RTL and testbench

Pipelined Barrett modular reducer that consumes the unsigned 30-bit coefficient products generated by the RLWE encryption multiplier stage. For each product it returns the canonical residue modulo Q, along with a coefficient-index tag that travels alongside it. It sits between the multiplier and the polynomial accumulate/store logic and uses valid/ready handshakes on both sides. Throughput is one result per cycle with fixed latency.

---
 rtl/rlwe_enc2_mod_reduce.sv | 163 ++++++++++++++++
 tb/tb_rlwe_enc2_mod_reduce.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rlwe_enc2_mod_reduce.sv
// Three-stage Barrett reducer: 30-bit products to canonical residues mod Q, tag carried alongside.
// Define RLWE_MODRED_RANGE_CHK_EN to enable the sticky err flag for inputs above (Q-1)^2.
module rlwe_enc2_mod_reduce #(
    parameter int IN_WIDTH  = 30,
    parameter int Q         = 7681,
    parameter int Q_WIDTH   = 14,
    parameter int BARRETT_K = 30,
    parameter int BARRETT_M = 139792,
    parameter int TAG_WIDTH = 8
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Q_WIDTH-1:0]   out_data,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic                 err
);

    localparam int M_WIDTH = $clog2(BARRETT_M + 1);
    localparam int P_WIDTH = IN_WIDTH + M_WIDTH;
    localparam int T_WIDTH = P_WIDTH - BARRETT_K;
    // Signed with one spare bit so r may sit anywhere in [-Q, 2Q): M rounded either way is tolerated.
    localparam int R_WIDTH = Q_WIDTH + 2;

    function automatic logic [Q_WIDTH-1:0] canon_residue(input logic signed [R_WIDTH-1:0] r);
        logic signed [R_WIDTH-1:0] qs;
        logic signed [R_WIDTH-1:0] res;
        qs = R_WIDTH'(Q);
        if (r[R_WIDTH-1]) begin
            res = r + qs;
        end else if (r >= qs) begin
            res = r - qs;
        end else begin
            res = r;
        end
        return Q_WIDTH'(res);
    endfunction

    logic                        adv;
    logic                        fire_in;

    logic                        s1_vld_q, s1_vld_d;
    logic        [IN_WIDTH-1:0]  s1_x_q, s1_x_d;
    logic        [P_WIDTH-1:0]   s1_p_q, s1_p_d;
    logic        [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;

    logic                        s2_vld_q, s2_vld_d;
    logic signed [R_WIDTH-1:0]   s2_r_q, s2_r_d;
    logic        [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;
    logic        [T_WIDTH-1:0]   s2_t;
    logic        [P_WIDTH-1:0]   s2_diff;

    logic                        out_vld_q, out_vld_d;
    logic        [Q_WIDTH-1:0]   out_data_q, out_data_d;
    logic        [TAG_WIDTH-1:0] out_tag_q, out_tag_d;

    assign adv      = !out_vld_q || out_ready;
    assign in_ready = adv;
    assign fire_in  = in_valid && adv;

    assign out_valid = out_vld_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;

    // Stage 1: capture product and form x*M
    always_comb begin
        s1_vld_d = s1_vld_q;
        s1_x_d   = s1_x_q;
        s1_p_d   = s1_p_q;
        s1_tag_d = s1_tag_q;
        if (adv) begin
            s1_vld_d = fire_in;
            if (fire_in) begin
                s1_x_d   = in_data;
                s1_p_d   = P_WIDTH'(in_data) * P_WIDTH'(BARRETT_M);
                s1_tag_d = in_tag;
            end
        end
    end

    // Stage 2: quotient estimate and first remainder
    always_comb begin
        s2_t     = T_WIDTH'(s1_p_q >> BARRETT_K);
        s2_diff  = P_WIDTH'(s1_x_q) - P_WIDTH'(s2_t) * P_WIDTH'(Q);
        s2_vld_d = s2_vld_q;
        s2_r_d   = s2_r_q;
        s2_tag_d = s2_tag_q;
        if (adv) begin
            s2_vld_d = s1_vld_q;
            s2_r_d   = R_WIDTH'(s2_diff);
            s2_tag_d = s1_tag_q;
        end
    end

    // Stage 3: final correction into [0, Q-1]
    always_comb begin
        out_vld_d  = out_vld_q;
        out_data_d = out_data_q;
        out_tag_d  = out_tag_q;
        if (adv) begin
            out_vld_d = s2_vld_q;
            if (s2_vld_q) begin
                out_data_d = canon_residue(s2_r_q);
                out_tag_d  = s2_tag_q;
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            out_tag_q  <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s2_vld_q   <= s2_vld_d;
            out_vld_q  <= out_vld_d;
            out_data_q <= out_data_d;
            out_tag_q  <= out_tag_d;
        end
    end

    always_ff @(posedge ap_clk) begin
        s1_x_q   <= s1_x_d;
        s1_p_q   <= s1_p_d;
        s1_tag_q <= s1_tag_d;
        s2_r_q   <= s2_r_d;
        s2_tag_q <= s2_tag_d;
    end

`ifdef RLWE_MODRED_RANGE_CHK_EN
    localparam logic [IN_WIDTH-1:0] RANGE_MAX = IN_WIDTH'((Q - 1) * (Q - 1));

    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (fire_in && (in_data > RANGE_MAX)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_rlwe_enc2_mod_reduce.sv
// Bench for rlwe_enc2_mod_reduce: vector table, directed stall/reset/err sequences, random scoreboard.
module tb_rlwe_enc2_mod_reduce;

    localparam int QM = 7681;
`ifdef RLWE_MODRED_RANGE_CHK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [29:0] in_data;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_data;
    logic [7:0]  out_tag;
    logic        err;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 ap_clk = ~ap_clk;

    rlwe_enc2_mod_reduce dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .err       (err)
    );

    typedef struct {
        logic [29:0] x;
        logic [7:0]  tag;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[10];
    vec_t stl[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
    endtask

    int          exp_q[$];
    logic [7:0]  tag_q[$];

    initial begin
        int          sent, got, extra, cyc;
        logic [7:0]  tagc;
        logic        stall;
        logic [13:0] sd;
        logic [7:0]  st;

        vecs[0] = '{30'd0,          8'd20, 14'd0};
        vecs[1] = '{30'd7681,       8'd21, 14'd0};
        vecs[2] = '{30'd58982400,   8'd22, 14'd1};
        vecs[3] = '{30'd1073741823, 8'd23, 14'd7152};
        vecs[4] = '{30'd7680,       8'd24, 14'd7680};
        vecs[5] = '{30'd15361,      8'd25, 14'd7680};
        vecs[6] = '{30'd1,          8'd26, 14'd1};
        vecs[7] = '{30'd768100005,  8'd27, 14'd5};
        vecs[8] = '{30'd1067666680, 8'd28, 14'd7680};
        vecs[9] = '{30'd7682,       8'd29, 14'd1};

        stl[0] = '{30'd7682,  8'd40, 14'd1};
        stl[1] = '{30'd23043, 8'd41, 14'd0};
        stl[2] = '{30'd30723, 8'd42, 14'd7680};

        in_valid  = 1'b0;
        in_data   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        ap_rst_n  = 1'b0;
        tick();
        tick();
        ap_rst_n = 1'b1;

        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_out_tag",   out_tag,   0);
        check("rst_err",       err,       0);
        check("rst_in_ready",  in_ready,  1);

        // Single zero product, latency three
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 30'd0;
        in_tag    = 8'd3;
        tick();
        in_valid = 1'b0;
        check("lat_c1_valid", out_valid, 0);
        tick();
        check("lat_c2_valid", out_valid, 0);
        tick();
        check("lat_c3_valid", out_valid, 1);
        check("lat_c3_data",  out_data,  0);
        check("lat_c3_tag",   out_tag,   3);
        check("lat_c3_err",   err,       0);
        tick();
        check("lat_c4_valid", out_valid, 0);

        // Range flag boundary
        in_valid = 1'b1;
        in_data  = 30'd58982400;
        in_tag   = 8'd10;
        tick();
        in_valid = 1'b0;
        tick();
        check("err_at_max", err, 0);
        in_valid = 1'b1;
        in_data  = 30'd58982401;
        tick();
        in_valid = 1'b0;
        check("err_set", err, CHK);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("err_sticky", err, CHK);
        end
        do_reset();
        check("err_cleared", err, 0);

        // Table vectors back to back
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 10);
            if (c < 10) begin
                in_data = vecs[c].x;
                in_tag  = vecs[c].tag;
            end
            tick();
            if (c >= 2 && c - 2 < 10) begin
                check("tbl_valid", out_valid, 1);
                check("tbl_data",  out_data,  vecs[c-2].exp);
                check("tbl_tag",   out_tag,   vecs[c-2].tag);
            end else begin
                check("tbl_idle", out_valid, 0);
            end
        end
        in_valid = 1'b0;
        tick();
        check("tbl_after", out_valid, 0);

        // Fill, stall five cycles, drain
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = stl[i].x;
            in_tag   = stl[i].tag;
            tick();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall_in_ready", in_ready, 0);
            check("stall_valid",    out_valid, 1);
            check("stall_data",     out_data, stl[0].exp);
            check("stall_tag",      out_tag,  stl[0].tag);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            check("drain_valid", out_valid, 1);
            check("drain_data",  out_data,  stl[i].exp);
            check("drain_tag",   out_tag,   stl[i].tag);
            tick();
        end
        check("drain_done", out_valid, 0);

        // Random traffic against x mod Q scoreboard
        sent  = 0;
        got   = 0;
        extra = 0;
        cyc   = 0;
        tagc  = 8'd0;
        while ((sent < 1000 || exp_q.size() > 0) && cyc < 20000) begin
            in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       in_data = '0;
                1:       in_data = '1;
                2:       in_data = 30'(QM * $urandom_range(0, 139000) + $urandom_range(7670, 7680));
                default: in_data = 30'($urandom);
            endcase
            in_tag    = tagc;
            out_ready = (sent >= 1000) || ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    extra++;
                end else begin
                    check("rnd_data", out_data, exp_q.pop_front());
                    check("rnd_tag",  out_tag,  tag_q.pop_front());
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(int'(in_data % QM));
                tag_q.push_back(in_tag);
                sent++;
                tagc++;
            end
            stall = out_valid && !out_ready;
            sd    = out_data;
            st    = out_tag;
            tick();
            cyc++;
            if (stall) begin
                check("rnd_hold_valid", out_valid, 1);
                check("rnd_hold_data",  out_data,  sd);
                check("rnd_hold_tag",   out_tag,   st);
            end
        end
        in_valid = 1'b0;
        check("rnd_count", got, 1000);
        check("rnd_extra", extra, 0);
        check("rnd_left",  exp_q.size(), 0);
        tick();
        check("rnd_idle", out_valid, 0);

        // Reset with three results in flight
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 30'(i + 100);
            in_tag   = 8'(i + 60);
            tick();
        end
        in_valid = 1'b0;
        check("flush_pre_valid", out_valid, 1);
        do_reset();
        check("flush_valid", out_valid, 0);
        check("flush_data",  out_data,  0);
        check("flush_tag",   out_tag,   0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("flush_no_stale", out_valid, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
